// File: rtl/ppwm_exec.sv
// Programmable PWM instruction sequencer.
// Fetches 16-bit instructions from a small write-only program memory and
// executes them against the PWM value register and a general register.
// The comparator's duty value is refreshed from the PWM register on every
// period boundary.

package ppwm_pkg;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_SET      = 3'd1,
    CMD_ARITH    = 3'd2,
    CMD_SHIFT    = 3'd3,
    CMD_WAIT     = 3'd4,
    CMD_JUMP     = 3'd5,
    CMD_CMP_CNTR = 3'd6,
    CMD_BRANCH   = 3'd7
  } command_e;

  typedef enum logic {
    TGT_PWM = 1'b0,
    TGT_REG = 1'b1
  } target_e;

endpackage

// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | disabled or just enabled; pc held at 0
// S_EXEC | one instruction per cycle from mem[pc]
// S_WAIT | parked on a WAIT instruction until the next period start
module ppwm_exec #(
  parameter  int DATA_W     = 8,
  parameter  int PROG_DEPTH = 16,
  localparam int ADDR_W     = $clog2(PROG_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [15:0]       prog_wdata_i,
  input  logic              period_start_i,
  input  logic [DATA_W-1:0] cntr_i,
  output logic [DATA_W-1:0] duty_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              waiting_o
);

  import ppwm_pkg::*;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] pwm_q;
  logic [DATA_W-1:0] reg_q;
  logic [DATA_W-1:0] duty_q;
  logic              flag_q;
  logic              waiting_q;

  logic [15:0]       mem [PROG_DEPTH];

  logic [15:0]       instr;
  command_e          cmd;
  target_e           tgt;
  logic [1:0]        fn;
  logic [7:0]        imm;
  logic              unused_rsvd;

  logic [DATA_W-1:0] t_val;
  logic [DATA_W-1:0] simm_d;
  logic [DATA_W-1:0] cmp_x;
  logic [DATA_W-1:0] t_res;
  logic              t_we;
  logic              cond;
  logic              flag_nxt;
  logic              go_wait;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_rel;
  logic [ADDR_W-1:0] pc_nxt;

  // Program memory: written at the clock edge, so the instruction executing
  // in the same cycle still sees the old word through the combinational read.
  always_ff @(posedge clk_i) begin
    if (prog_we_i) begin
      mem[prog_addr_i] <= prog_wdata_i;
    end
  end

  assign instr       = mem[pc_q];
  assign cmd         = command_e'(instr[15:13]);
  assign tgt         = target_e'(instr[12]);
  assign fn          = instr[9:8];
  assign imm         = instr[7:0];
  assign unused_rsvd = ^instr[11:10];

  assign t_val  = (tgt == TGT_REG) ? reg_q : pwm_q;
  assign simm_d = DATA_W'($signed(imm));
  assign cmp_x  = (tgt == TGT_REG) ? reg_q : DATA_W'(imm);

  // Relative PC targets only need the low address bits of the sign-extended
  // immediate, since PC arithmetic wraps at the memory depth.
  assign pc_inc = pc_q + ADDR_W'(1);
  assign pc_rel = pc_q + imm[ADDR_W-1:0];

  // Counter compare condition selected by fn.
  always_comb begin
    cond = 1'b0;
    case (fn)
      2'b00:   cond = (cntr_i == cmp_x);
      2'b01:   cond = (cntr_i != cmp_x);
      2'b10:   cond = (cntr_i <  cmp_x);
      2'b11:   cond = (cntr_i >= cmp_x);
      default: cond = 1'b0;
    endcase
  end

  // Instruction decode/execute: register result, next pc, flag and wait request.
  always_comb begin
    t_res    = t_val;
    t_we     = 1'b0;
    pc_nxt   = pc_inc;
    flag_nxt = flag_q;
    go_wait  = 1'b0;
    case (cmd)
      CMD_NOP: ;
      CMD_SET: begin
        t_res = DATA_W'(imm);
        t_we  = 1'b1;
      end
      CMD_ARITH: begin
        t_res = t_val + simm_d;
        t_we  = 1'b1;
      end
      CMD_SHIFT: begin
        t_res = fn[0] ? (t_val >> imm[2:0]) : (t_val << imm[2:0]);
        t_we  = 1'b1;
      end
      CMD_WAIT: begin
        go_wait = 1'b1;
        pc_nxt  = pc_q;
      end
      CMD_JUMP: begin
        pc_nxt = pc_rel;
      end
      CMD_CMP_CNTR: begin
        flag_nxt = cond;
      end
      CMD_BRANCH: begin
        if (flag_q) begin
          pc_nxt = pc_rel;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM plus data registers; duty sampling runs independently of
  // state so the comparator keeps tracking the PWM register while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      pwm_q     <= '0;
      reg_q     <= '0;
      flag_q    <= 1'b0;
      duty_q    <= '0;
      waiting_q <= 1'b0;
    end else begin
      if (period_start_i) begin
        duty_q <= pwm_q;
      end
      if (!enable_i) begin
        state_q   <= S_IDLE;
        pc_q      <= '0;
        waiting_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q   <= S_EXEC;
            pc_q      <= '0;
            waiting_q <= 1'b0;
          end
          S_EXEC: begin
            pc_q   <= pc_nxt;
            flag_q <= flag_nxt;
            if (t_we) begin
              if (tgt == TGT_REG) begin
                reg_q <= t_res;
              end else begin
                pwm_q <= t_res;
              end
            end
            if (go_wait) begin
              state_q   <= S_WAIT;
              waiting_q <= 1'b1;
            end
          end
          S_WAIT: begin
            // A pulse in the cycle the WAIT executed was seen in S_EXEC,
            // so only a later pulse reaches this release.
            if (period_start_i) begin
              state_q   <= S_EXEC;
              pc_q      <= pc_inc;
              waiting_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            waiting_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_o    = duty_q;
  assign pc_o      = pc_q;
  assign waiting_o = waiting_q;

endmodule

// File: doc/ppwm_exec.md
# ppwm_exec

Instruction sequencer for the programmable PWM: holds a small program memory, fetches and decodes the 3-bit `command_e` opcodes from `ppwm_pkg`, and executes them against two 8-bit data registers (PWM value and general register). It sits between the configuration write port and the PWM counter/comparator. It produces the duty value that the comparator uses, updated at each PWM period boundary.

## Interface
Parameters:
- `DATA_W`, 8: width of the PWM value, the general register and the counter compare.
- `PROG_DEPTH`, 16: number of instruction words; power of two. `ADDR_W = $clog2(PROG_DEPTH)`.

Ports:
- `clk_i`  in  1  clock; the only clock.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  run control; high means execute, low means idle.
- `prog_we_i`  in  1  program memory write strobe.
- `prog_addr_i`  in  ADDR_W  program write address.
- `prog_wdata_i`  in  16  instruction word.
- `period_start_i`  in  1  one-cycle pulse from the PWM counter on the first cycle of each period.
- `cntr_i`  in  DATA_W  global PWM counter value.
- `duty_o`  out  DATA_W  registered duty value for the comparator.
- `pc_o`  out  ADDR_W  current program counter.
- `waiting_o`  out  1  high while in state WAIT.

## Operation
Instruction word fields:
- `[15:13]` cmd (`command_e`).
- `[12]` target (`target_e`: PWM=0, REG=1).
- `[9:8]` fn.
- `[7:0]` imm.
- `[11:10]` reserved, ignored.

Notation: T is the register selected by target; `simm` is imm sign-extended. All arithmetic is modulo 2^DATA_W, and PC arithmetic is modulo PROG_DEPTH.
- NOP: pc+1.
- SET: T <= imm; pc+1.
- ARITH: T <= T + simm (wraps, no saturation); pc+1.
- SHIFT: fn[0]=0 means logical left, 1 means logical right, by imm[2:0] (0..7); pc+1.
- WAIT: enter WAIT; pc is unchanged until release.
- JUMP: pc <= pc + simm[ADDR_W-1:0] (wraps).
- CMP_CNTR: flag <= cond(`cntr_i`, X), where X = imm if target=PWM, X = reg if target=REG. Conditions by fn: 00 eq, 01 ne, 10 `cntr_i` < X (unsigned), 11 `cntr_i` >= X. Then pc+1.
- BRANCH: if flag, pc <= pc + simm; else pc+1. flag is not modified.

State machine `{IDLE, EXEC, WAIT}`:
- IDLE: pc=0. When `enable_i` is high, go to EXEC.
- EXEC: executes one instruction per cycle. The memory read is combinational at pc, so the fetched word is `mem[pc]`. WAIT goes to state WAIT.
- WAIT: on `period_start_i`, pc <= pc+1 and return to EXEC. A pulse in the same cycle the WAIT instruction executes does not release it.
- Any state: `enable_i` low forces IDLE and pc=0 on the next edge. pwm, reg, flag and `duty_o` are retained.

Duty update:
- On every `period_start_i`, `duty_o` <= pwm register value before any same-cycle update.
- This happens in every state, including IDLE.

Program writes:
- Allowed in any state.
- A write to `mem[pc]` in the same cycle the instruction executes does not affect that execution; the old word executes.
- Program memory is not reset; content is undefined until written.

## Timing
Reset values: state=IDLE, pc=0, pwm=0, reg=0, flag=0, `duty_o`=0, `waiting_o`=0, `pc_o`=0.

- Instruction latency: 1 cycle. The register result is visible the cycle after execute.
- `enable_i` rising at edge N means the instruction at pc 0 executes in cycle N+1.
- WAIT release: pulse at edge M means the next instruction executes in cycle M+1.
- Throughput: 1 instruction per cycle with no stalls except WAIT.
- `waiting_o` is a registered output, equal to (state==WAIT).

## Test plan
- Reset/duty: program SET PWM 0x40, WAIT, JUMP -1. Enable, then pulse `period_start_i` twice. Required: `duty_o` is 0x00 before the first pulse and 0x40 after it; `waiting_o` is high between pulses.
- Arithmetic wrap: SET REG 0xFF, ARITH REG +1 gives reg=0x00. ARITH PWM -1 from 0x00 gives 0xFF. SHIFT right 3 of 0xF0 gives 0x1E. SHIFT left 7 of 0x03 gives 0x80.
- PC wrap: JUMP -1 at pc 0 gives pc=15. JUMP +1 at pc 15 gives pc=0.
- Compare/branch: `cntr_i`=0x20. CMP_CNTR fn=10 imm=0x30 sets flag=1, then BRANCH +3 jumps pc+3. CMP_CNTR fn=00 target=REG with reg=0x21 sets flag=0, then BRANCH falls through to pc+1.
- WAIT same-cycle pulse: assert `period_start_i` in the cycle WAIT executes. Required: it stays in WAIT and releases only on the next pulse.
- Disable mid-WAIT: drop `enable_i` while in WAIT. Required: IDLE with pc=0, `waiting_o`=0, pwm and `duty_o` unchanged. Re-enable restarts at pc 0.
